data_cache: RTL

Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and the block-wide data memory. Serves 32-bit word reads and writes from the CPU in one cycle on a hit. On a miss it stalls the CPU, writes back a dirty victim line, fills the line from memory, then replays the access as a hit. Keeps hit and miss counters for performance evaluation.

---
 rtl/cache_pkg.sv | 43 ++++
 rtl/cache_line_array.sv | 59 +++++
 rtl/data_cache.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared state encoding, address-geometry helpers and the cache line record
// used by the data cache and its line storage.
package cache_pkg;

  localparam int unsigned DEF_LINE_SIZE = 16;
  localparam int unsigned DEF_NUM_SETS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    ALLOC_REQ,
    ALLOC_WAIT
  } state_t;

  function automatic int unsigned off_bits_f(input int unsigned line_size);
    return $clog2(line_size);
  endfunction

  function automatic int unsigned idx_bits_f(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits_f(input int unsigned line_size,
                                             input int unsigned num_sets);
    return 32 - off_bits_f(line_size) - idx_bits_f(num_sets);
  endfunction

  // A one-word line still needs a 1-bit (always zero) word select.
  function automatic int unsigned wsel_bits_f(input int unsigned line_size);
    return (off_bits_f(line_size) > 2) ? off_bits_f(line_size) - 2 : 1;
  endfunction

  localparam int unsigned DEF_TAG_BITS = tag_bits_f(DEF_LINE_SIZE, DEF_NUM_SETS);

  typedef struct packed {
    logic                         valid;
    logic                         dirty;
    logic [DEF_TAG_BITS-1:0]      tag;
    logic [DEF_LINE_SIZE*8-1:0]   data;
  } line_t;

endpackage

// File: rtl/cache_line_array.sv
// Line storage: combinational read of one set, word write for CPU store hits,
// whole-line fill from memory, and synchronous clear of valid/dirty on reset.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned LINE_SIZE = DEF_LINE_SIZE,
  parameter int unsigned NUM_SETS  = DEF_NUM_SETS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [idx_bits_f(NUM_SETS)-1:0]     idx,
  input  logic                                word_we,
  input  logic [wsel_bits_f(LINE_SIZE)-1:0]   word_sel,
  input  logic [31:0]                         word_data,
  input  logic                                fill_we,
  input  logic [tag_bits_f(LINE_SIZE, NUM_SETS)-1:0] fill_tag,
  input  logic [LINE_SIZE*8-1:0]              fill_data,
  output line_t                               line
);

  localparam int unsigned TAG_BITS  = tag_bits_f(LINE_SIZE, NUM_SETS);
  localparam int unsigned LINE_BITS = LINE_SIZE * 8;

  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only trusted once valid is set.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_we) begin
      data_q[idx][{word_sel, 5'b0} +: 32] <= word_data;
    end
  end

  always_comb begin
    line       = '0;
    line.valid = valid_q[idx];
    line.dirty = dirty_q[idx];
    line.tag   = tag_q[idx];
    line.data  = data_q[idx];
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: single-cycle hits,
// stall with write-back/fill on a miss, then the held access replays as a hit.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned LINE_SIZE = DEF_LINE_SIZE,
  parameter int unsigned NUM_SETS  = DEF_NUM_SETS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            din,
  output logic                   is_ready,
  output logic                   is_output_valid,
  output logic [31:0]            dout,
  output logic                   is_hit,
  output logic                   dm_is_input_valid,
  output logic [31:0]            dm_addr,
  output logic                   dm_read,
  output logic                   dm_write,
  output logic [LINE_SIZE*8-1:0] dm_din,
  input  logic                   dm_is_output_valid,
  input  logic [LINE_SIZE*8-1:0] dm_dout,
  input  logic                   dm_ready,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  localparam int unsigned OFF_BITS  = off_bits_f(LINE_SIZE);
  localparam int unsigned IDX_BITS  = idx_bits_f(NUM_SETS);
  localparam int unsigned TAG_BITS  = tag_bits_f(LINE_SIZE, NUM_SETS);
  localparam int unsigned WSEL_BITS = wsel_bits_f(LINE_SIZE);

  // Memory handshake: a request is offered only in the *_REQ states and only
  // while dm_ready=1; memory takes it on that edge and drops dm_ready, so
  // dm_is_input_valid is a one-cycle pulse. dm_ready returning high marks
  // completion, with dm_is_output_valid qualifying dm_dout for fills.

  state_t               state, state_next;
  line_t                line;
  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic [WSEL_BITS-1:0] word_sel;
  logic [31:0]          word;
  logic                 access, hit, word_we, fill_we, replay_q;
  logic                 unused_byte_bits;

  assign idx    = addr[OFF_BITS +: IDX_BITS];
  assign tag    = addr[31 -: TAG_BITS];
  assign access = is_input_valid && (mem_read || mem_write);
  assign hit    = line.valid && (line.tag == tag);
  assign word   = line.data[{word_sel, 5'b0} +: 32];
  assign unused_byte_bits = ^addr[1:0];

  generate
    if (OFF_BITS > 2) begin : g_wsel
      assign word_sel = addr[2 +: WSEL_BITS];
    end else begin : g_wsel_single
      assign word_sel = '0;
    end
  endgenerate

  cache_line_array #(
    .LINE_SIZE (LINE_SIZE),
    .NUM_SETS  (NUM_SETS)
  ) u_lines (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (din),
    .fill_we   (fill_we),
    .fill_tag  (tag),
    .fill_data (dm_dout),
    .line      (line)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    is_ready          = 1'b0;
    is_output_valid   = 1'b0;
    dout              = '0;
    is_hit            = 1'b0;
    dm_is_input_valid = 1'b0;
    dm_addr           = '0;
    dm_read           = 1'b0;
    dm_write          = 1'b0;
    dm_din            = '0;
    word_we           = 1'b0;
    fill_we           = 1'b0;
    unique case (state)
      IDLE: begin
        is_ready = 1'b1;
        if (access) begin
          if (hit) begin
            is_hit          = 1'b1;
            is_output_valid = 1'b1;
            // A request with both commands set is a store.
            if (mem_write) word_we = 1'b1;
            else           dout    = word;
          end else if (line.valid && line.dirty) begin
            state_next = WB_REQ;
          end else begin
            state_next = ALLOC_REQ;
          end
        end
      end
      WB_REQ: begin
        dm_write          = 1'b1;
        dm_is_input_valid = dm_ready;
        dm_addr           = {{OFF_BITS{1'b0}}, line.tag, idx};
        dm_din            = line.data;
        if (dm_ready) state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (dm_ready) state_next = ALLOC_REQ;
      end
      ALLOC_REQ: begin
        dm_read           = 1'b1;
        dm_is_input_valid = dm_ready;
        dm_addr           = {{OFF_BITS{1'b0}}, addr[31:OFF_BITS]};
        if (dm_ready) state_next = ALLOC_WAIT;
      end
      ALLOC_WAIT: begin
        if (dm_is_output_valid) begin
          fill_we    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The replay after a fill hits, but it was already counted as a miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        replay_q <= 1'b0;
        if (access && hit && !replay_q) hit_count  <= hit_count + 32'd1;
        if (access && !hit)             miss_count <= miss_count + 32'd1;
      end
      if (fill_we) replay_q <= 1'b1;
    end
  end

endmodule
